icache_fill_responder: RTL and testbench
========================================

Name: icache_fill_responder

Overview:
- Responder side of the instruction-fetch interface: serves the fetch unit's PC-addressed reads from a small direct-mapped instruction cache.
- A hit returns the instruction in the same cycle.
- A miss holds the fetch stage stalled while a fill FSM reads the whole line from instruction memory, one word per memory handshake.
- The cache is read-only; fetch_flush invalidates all lines.

Parameters:
- LINES, 8, number of cache lines; power of 2.
- WORDS, 4, 16-bit words per line; power of 2.
- AW, 16, byte address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- fetch_req  in  1  fetch unit requests the instruction at fetch_addr this cycle
- fetch_addr  in  AW  byte address (PC); bit 0 ignored
- fetch_flush  in  1  invalidate all lines
- fetch_ready  out  1  fetch_instr valid this cycle (hit)
- fetch_stall  out  1  request pending but not served; fetch unit holds PC
- fetch_instr  out  16  instruction; 16'h0000 when fetch_ready=0
- mem_rd_req  out  1  line-word read request to instruction memory
- mem_addr  out  AW  word-aligned byte address of the requested word
- mem_rd_valid  in  1  memory returns mem_rd_data for the current request
- mem_rd_data  in  16  returned word

Behaviour:
- Reset: rst synchronous, active-low; clock clk.
  - All valid bits are cleared and the FSM goes to IDLE.
  - fetch_ready, fetch_stall and mem_rd_req are 0; fetch_instr and mem_addr are 0.
  - Reset mid-fill aborts the fill; the partial line stays invalid.
- Address split:
  - offset = addr[log2(WORDS):1]
  - index = next log2(LINES) bits
  - tag = remaining upper bits (default: offset [2:1], index [5:3], tag [15:6]).
- Storage:
  - Per line: valid bit, tag, WORDS x 16 data.
  - Data written only by the fill FSM.
- Hit:
  - hit = fetch_req & state==IDLE & valid[index] & tag match.
  - fetch_ready = hit and fetch_instr = data[index][offset], both combinational (same cycle).
  - fetch_stall = fetch_req & !hit.
- FSM states: IDLE, FILL, DONE.
  - IDLE -> FILL on fetch_req & miss & !fetch_flush.
    - Latch fill_tag and fill_index; clear word count cnt=0.
    - Clear valid[index] at this edge.
  - FILL:
    - mem_rd_req=1 and mem_addr = {fill_tag, fill_index, cnt, 1'b0}, held stable until mem_rd_valid.
    - On each mem_rd_valid: write mem_rd_data to data[fill_index][cnt] and increment cnt.
    - On the valid for cnt==WORDS-1: set valid[fill_index], write the tag, go to DONE.
    - mem_rd_valid outside FILL is ignored.
    - Memory must not return data after mem_rd_req drops.
  - DONE: one bubble cycle (fetch_stall=fetch_req, mem_rd_req=0), then back to IDLE. The retried request hits the following cycle.
- Fetch address during fill: fetch_addr may change during FILL (for example, a branch redirect). The fill still completes; the new address is looked up on return to IDLE.
- Flush:
  - fetch_flush clears all valid bits at the clock edge.
  - In FILL it aborts the fill (mem_rd_req low the next cycle) and the FSM returns to IDLE with the line invalid.
  - Flush has priority over a same-cycle fill completion or miss.
  - fetch_ready is forced 0 in the flush cycle.
- Fill latency: a miss with memory latency L cycles per word stalls for 1 (miss detect) + WORDS*(L+1) + 1 (DONE) cycles before the hit.
- Back-to-back mem_rd_valid (L=0) is legal: one word per cycle.

Test Plan:
1. Cold miss: after reset, fetch_req=1, fetch_addr=0x0000, memory returns 0x1000+addr after 1-cycle latency -> mem_addr sequence 0x0000, 0x0002, 0x0004, 0x0006. fetch_stall high throughout, then fetch_ready=1 with fetch_instr=0x1000.
2. Line hits: following fetches at 0x0002, 0x0004, 0x0006 -> fetch_ready=1 each cycle with instrs 0x1002, 0x1004, 0x1006; mem_rd_req stays 0.
3. Conflict eviction: fetch 0x0040 (index 0, tag 1) -> fill of 0x0040..0x0046. A later fetch of 0x0000 misses again and refills.
4. Flush mid-fill: assert fetch_flush after the 2nd word of a fill at 0x0008 -> mem_rd_req drops the next cycle and line 1 stays invalid. A re-fetch of 0x0008 restarts the fill at mem_addr 0x0008.
5. Reset mid-fill: rst=0 for one cycle during FILL -> all outputs 0, state IDLE. The previously valid line at 0x0000 now misses.
6. Idle/stray response: fetch_req=0 with a stray mem_rd_valid pulse -> no state change, no data written; fetch_stall=0 and fetch_ready=0.

Source files
------------

// File: rtl/icache_fill_responder.sv
// Instruction-cache responder for the fetch unit. The cache is direct mapped, read only, and
// has LINES lines of WORDS 16-bit words each.
// A hit returns the instruction combinationally in the same cycle. A miss starts a fill FSM
// that reads the whole line from instruction memory, one word per memory handshake, and stalls
// the fetch unit until the line is present.
module icache_fill_responder #(
    parameter int unsigned LINES = 8,
    parameter int unsigned WORDS = 4,
    parameter int unsigned AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    input  logic          fetch_flush,
    output logic          fetch_ready,
    output logic          fetch_stall,
    output logic [15:0]   fetch_instr,
    output logic          mem_rd_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_rd_valid,
    input  logic [15:0]   mem_rd_data
);

    localparam int unsigned OW = $clog2(WORDS);
    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = AW - 1 - OW - IW;

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    // Address split: byte bit 0 is dropped, then offset, index, tag.
    logic [OW-1:0] addr_off;
    logic [IW-1:0] addr_idx;
    logic [TW-1:0] addr_tag;
    logic          unused_addr0;

    assign addr_off     = fetch_addr[OW:1];
    assign addr_idx     = fetch_addr[OW+IW:OW+1];
    assign addr_tag     = fetch_addr[AW-1:OW+IW+1];
    assign unused_addr0 = fetch_addr[0];

    // Cache storage. Only the valid bits are reset: a line is never used while invalid.
    logic [LINES-1:0] valid_q, valid_d;
    logic [TW-1:0]    tag_q  [LINES];
    logic [15:0]      data_q [LINES][WORDS];

    // Fill FSM state.
    state_e        state_q, state_d;
    logic [TW-1:0] fill_tag_q, fill_tag_d;
    logic [IW-1:0] fill_idx_q, fill_idx_d;
    logic [OW-1:0] cnt_q, cnt_d;

    logic lookup_hit;
    logic served;
    logic data_we;
    logic tag_we;

    // Lookup and fetch-side outputs. A flush cycle never serves. While rst is low, every
    // output is held at zero.
    always_comb begin
        lookup_hit  = fetch_req & (state_q == StIdle) & valid_q[addr_idx] &
                      (tag_q[addr_idx] == addr_tag);
        served      = rst & lookup_hit & ~fetch_flush;
        fetch_ready = served;
        fetch_instr = served ? data_q[addr_idx][addr_off] : 16'h0000;
        fetch_stall = rst & fetch_req & ~served;
        mem_rd_req  = rst & (state_q == StFill);
        mem_addr    = mem_rd_req ? {fill_tag_q, fill_idx_q, cnt_q, 1'b0} : '0;
    end

    // Next-state logic for the fill FSM and the valid bits. A flush overrides everything else.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        fill_tag_d = fill_tag_q;
        fill_idx_d = fill_idx_q;
        cnt_d      = cnt_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        if (fetch_flush) begin
            valid_d = '0;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fetch_req && !lookup_hit) begin
                        state_d           = StFill;
                        fill_tag_d        = addr_tag;
                        fill_idx_d        = addr_idx;
                        cnt_d             = '0;
                        // The victim line is invalid from here until its fill completes.
                        valid_d[addr_idx] = 1'b0;
                    end
                end
                StFill: begin
                    if (mem_rd_valid) begin
                        data_we = 1'b1;
                        cnt_d   = cnt_q + OW'(1);
                        if (cnt_q == OW'(WORDS - 1)) begin
                            valid_d[fill_idx_q] = 1'b1;
                            tag_we              = 1'b1;
                            state_d             = StDone;
                        end
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM and valid-bit registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            fill_tag_q <= fill_tag_d;
            fill_idx_q <= fill_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    // Line data and tag arrays. They are written only by the fill FSM.
    always_ff @(posedge clk) begin
        if (rst && data_we) begin
            data_q[fill_idx_q][cnt_q] <= mem_rd_data;
        end
        if (rst && tag_we) begin
            tag_q[fill_idx_q] <= fill_tag_q;
        end
    end

endmodule

// File: tb/tb_icache_fill_responder.sv
// Self-checking bench for icache_fill_responder.
// A behavioural cache model (line base addresses, a word array and a fill phase) predicts
// every output on every cycle. Directed scenarios pin the model with literal values, and a
// randomized phase then exercises the design against the model.
module tb_icache_fill_responder;

    localparam int LINES = 8;
    localparam int WORDS = 4;
    localparam int AW    = 16;
    localparam int LINE_BYTES = 2 * WORDS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_flush = 1'b0;
    logic          fetch_ready;
    logic          fetch_stall;
    logic [15:0]   fetch_instr;
    logic          mem_rd_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_valid = 1'b0;
    logic [15:0]   mem_rd_data = '0;

    icache_fill_responder #(
        .LINES (LINES),
        .WORDS (WORDS),
        .AW    (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_flush  (fetch_flush),
        .fetch_ready  (fetch_ready),
        .fetch_stall  (fetch_stall),
        .fetch_instr  (fetch_instr),
        .mem_rd_req   (mem_rd_req),
        .mem_addr     (mem_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the cache contents and of the fill in progress.
    typedef enum int {MIdle, MFill, MDone} mphase_e;
    bit          m_vld     [LINES];
    logic [15:0] m_base_of [LINES];
    logic [15:0] m_data    [LINES][WORDS];
    mphase_e     m_phase = MIdle;
    logic [15:0] m_base  = '0;
    int          m_cnt   = 0;

    // Memory responder: it answers lat cycles after each request starts.
    int lat     = 1;
    int lat_cnt = 0;

    // Values observed in the last step.
    logic        obs_ready, obs_stall, obs_req, obs_mv;
    logic [15:0] obs_instr, obs_maddr;
    logic [15:0] seen[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs with the model, then advance the model.
    task automatic step(input bit req, input logic [15:0] addr, input bit flush,
                        input bit rst_v, input bit stray);
        bit          mv;
        logic [15:0] md;
        bit          served;
        logic [15:0] base;
        int          idx, off;
        bit          e_stall, e_req;
        logic [15:0] e_instr, e_maddr;
        @(negedge clk);
        mv = 1'b0;
        md = 16'($urandom);
        if (rst_v && m_phase == MFill && lat_cnt >= lat) begin
            mv = 1'b1;
            md = mem_word(m_base + 16'(2 * m_cnt));
        end else if (stray && m_phase != MFill) begin
            mv = 1'b1;
        end
        rst          = rst_v;
        fetch_req    = req;
        fetch_addr   = addr;
        fetch_flush  = flush;
        mem_rd_valid = mv;
        mem_rd_data  = md;
        #1;
        base    = addr - (addr % 16'(LINE_BYTES));
        idx     = int'(addr / 16'(LINE_BYTES)) % LINES;
        off     = int'(addr / 16'd2) % WORDS;
        served  = rst_v && req && !flush && m_phase == MIdle && m_vld[idx] &&
                  m_base_of[idx] == base;
        e_instr = served ? m_data[idx][off] : 16'h0000;
        e_stall = rst_v && req && !served;
        e_req   = rst_v && m_phase == MFill;
        e_maddr = e_req ? m_base + 16'(2 * m_cnt) : 16'h0000;
        check("fetch_ready", 16'(fetch_ready), 16'(served));
        check("fetch_instr", fetch_instr, e_instr);
        check("fetch_stall", 16'(fetch_stall), 16'(e_stall));
        check("mem_rd_req", 16'(mem_rd_req), 16'(e_req));
        check("mem_addr", mem_addr, e_maddr);
        obs_ready = fetch_ready;
        obs_stall = fetch_stall;
        obs_req   = mem_rd_req;
        obs_instr = fetch_instr;
        obs_maddr = mem_addr;
        obs_mv    = mv;
        if (!rst_v || flush) begin
            for (int i = 0; i < LINES; i++) m_vld[i] = 1'b0;
            m_phase = MIdle;
            lat_cnt = 0;
        end else begin
            case (m_phase)
                MIdle: begin
                    if (req && !served) begin
                        m_phase    = MFill;
                        m_base     = base;
                        m_cnt      = 0;
                        m_vld[idx] = 1'b0;
                        lat_cnt    = 0;
                    end
                end
                MFill: begin
                    if (mv) begin
                        m_data[int'(m_base / 16'(LINE_BYTES)) % LINES][m_cnt] = md;
                        m_cnt++;
                        lat_cnt = 0;
                        if (m_cnt == WORDS) begin
                            m_vld[int'(m_base / 16'(LINE_BYTES)) % LINES]     = 1'b1;
                            m_base_of[int'(m_base / 16'(LINE_BYTES)) % LINES] = m_base;
                            m_phase = MDone;
                        end
                    end else begin
                        lat_cnt++;
                    end
                end
                default: m_phase = MIdle;
            endcase
        end
    endtask

    // Hold a request at addr until it is served. Records the addresses memory answered.
    task automatic run_until_hit(input logic [15:0] addr, output int stalls);
        seen.delete();
        stalls = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, addr, 1'b0, 1'b1, 1'b0);
            if (obs_mv) seen.push_back(obs_maddr);
            if (obs_stall) stalls++;
            if (obs_ready) break;
        end
        check("hit_reached", 16'(obs_ready), 16'd1);
    endtask

    function automatic logic [15:0] rand_addr();
        return 16'($urandom_range(0, 255)) * 16'd2;
    endfunction

    initial begin
        int          stalls;
        int          nw;
        logic [15:0] cur;
        bit          rq, fl, rv, st;

        // Reset: all outputs are zero.
        step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("reset_req", 16'(obs_req), 16'd0);
        check("reset_stall", 16'(obs_stall), 16'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("idle_ready", 16'(obs_ready), 16'd0);

        // Cold miss at 0x0000 with latency 1: stall lasts 1 + 4*2 + 1 cycles.
        lat = 1;
        run_until_hit(16'h0000, stalls);
        check("cold_nwords", 16'(seen.size()), 16'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            check("cold_mem_addr", seen[i], 16'(2 * i));
        check("cold_stalls", 16'(stalls), 16'd10);
        check("cold_instr", obs_instr, 16'h1000);

        // Hits within the line.
        for (int i = 1; i < 4; i++) begin
            step(1'b1, 16'(2 * i), 1'b0, 1'b1, 1'b0);
            check("line_hit_ready", 16'(obs_ready), 16'd1);
            check("line_hit_instr", obs_instr, 16'h1000 + 16'(2 * i));
            check("line_hit_noreq", 16'(obs_req), 16'd0);
        end

        // Conflict eviction: 0x0040 shares index 0 with 0x0000.
        run_until_hit(16'h0040, stalls);
        check("evict_first_addr", (seen.size() > 0) ? seen[0] : 16'hFFFF, 16'h0040);
        check("evict_last_addr", (seen.size() > 3) ? seen[3] : 16'hFFFF, 16'h0046);
        check("evict_instr", obs_instr, 16'h1040);
        run_until_hit(16'h0000, stalls);
        check("refill_stalls", 16'(stalls), 16'd10);
        check("refill_instr", obs_instr, 16'h1000);

        // Flush after the second word of a fill at 0x0008.
        nw = 0;
        for (int i = 0; i < 30 && nw < 2; i++) begin
            step(1'b1, 16'h0008, 1'b0, 1'b1, 1'b0);
            if (obs_mv) nw++;
        end
        check("flush_words_before", 16'(nw), 16'd2);
        step(1'b1, 16'h0008, 1'b1, 1'b1, 1'b0);
        check("flush_cycle_req", 16'(obs_req), 16'd1);
        check("flush_cycle_ready", 16'(obs_ready), 16'd0);
        step(1'b0, 16'h0008, 1'b0, 1'b1, 1'b0);
        check("after_flush_req", 16'(obs_req), 16'd0);
        run_until_hit(16'h0008, stalls);
        check("reflush_first_addr", (seen.size() > 0) ? seen[0] : 16'hFFFF, 16'h0008);
        check("reflush_stalls", 16'(stalls), 16'd10);
        check("reflush_instr", obs_instr, 16'h1008);

        // Reset in the middle of a fill. Line 0 is valid beforehand and misses afterwards.
        run_until_hit(16'h0000, stalls);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0010, 1'b0, 1'b1, 1'b0);
        check("midfill_req", 16'(obs_req), 16'd1);
        step(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        check("rst_req", 16'(obs_req), 16'd0);
        check("rst_stall", 16'(obs_stall), 16'd0);
        check("rst_maddr", obs_maddr, 16'h0000);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("post_rst_req", 16'(obs_req), 16'd0);
        run_until_hit(16'h0000, stalls);
        check("post_rst_stalls", 16'(stalls), 16'd10);

        // A stray memory response while idle is ignored.
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        check("stray_stall", 16'(obs_stall), 16'd0);
        check("stray_ready", 16'(obs_ready), 16'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("stray_noreq", 16'(obs_req), 16'd0);
        step(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("stray_hit_instr", obs_instr, 16'h1000);
        check("stray_hit_stall", 16'(obs_stall), 16'd0);

        // Randomized traffic against the model.
        cur = rand_addr();
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) lat = $urandom_range(0, 2);
            if (!obs_stall || $urandom_range(0, 9) == 0)
                cur = ($urandom_range(0, 9) < 6) ? ((cur + 16'd2) & 16'h01FE) : rand_addr();
            rq = $urandom_range(0, 3) != 0;
            fl = $urandom_range(0, 49) == 0;
            rv = $urandom_range(0, 199) != 0;
            st = $urandom_range(0, 19) == 0;
            step(rq, cur, fl, rv, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
